button_debouncer: RTL and testbench

//   Input-side companion to the LED output blocks: reads one raw mechanical

---
 rtl/button_debouncer.sv | 118 +++++++++++
 tb/tb_button_debouncer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser and debouncer
// Emits debounced level, press/release/hold pulses and a modulo-256 press count.
module button_debouncer #(
  parameter int CLOCK_RATE_HZ   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = CLOCK_RATE_HZ / 100,
  parameter int HOLD_CYCLES     = CLOCK_RATE_HZ
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn,
  output logic       o_btn,
  output logic       o_press,
  output logic       o_release,
  output logic       o_hold,
  output logic [7:0] o_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= RELEASED;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      o_btn     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_hold    <= 1'b0;
      o_count   <= 8'd0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_hold    <= 1'b0;

      case (state)
        RELEASED: begin
          if (s2) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s2) begin
            state <= RELEASED;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= PRESSED;
            o_btn    <= 1'b1;
            o_press  <= 1'b1;
            o_count  <= o_count + 8'd1;
            hold_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end

        PRESSED: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
          // Saturation at HOLD_MAX is what makes the hold pulse one-shot.
          if (hold_cnt == HOLD_LAST) o_hold <= 1'b1;
          if (!s2) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
          // Suppress a hold that would coincide with the release edge.
          if (hold_cnt == HOLD_LAST && (s2 || deb_cnt != DEB_LAST)) o_hold <= 1'b1;
          if (s2) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= RELEASED;
            o_btn     <= 1'b0;
            o_release <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end

        default: begin
          state <= RELEASED;
          o_btn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
// Compares every cycle against a run-length reference model.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int H = 20;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_btn = 1'b0;
  logic       o_btn;
  logic       o_press;
  logic       o_release;
  logic       o_hold;
  logic [7:0] o_count;

  button_debouncer #(
    .CLOCK_RATE_HZ  (50_000_000),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_btn    (i_btn),
    .o_btn    (o_btn),
    .o_press  (o_press),
    .o_release(o_release),
    .o_hold   (o_hold),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the level flips once the synced pin has disagreed with
  // it for D+1 consecutive edges; hold fires H edges after the press edge.
  bit m_p1, m_p2;
  bit m_level, m_press, m_rel, m_hold;
  int m_run, m_count, m_edge, m_press_edge;

  int seg_steps, seg_press_at, seg_rel_at, seg_hold_at;
  int seg_press_n, seg_rel_n, seg_hold_n;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_hold = 0;
    m_run = 0; m_count = 0; m_edge = 0; m_press_edge = -1000;
  endtask

  task automatic model_edge(input bit b);
    bit synced;
    synced  = m_p2;
    m_p2    = m_p1;
    m_p1    = b;
    m_press = 0; m_rel = 0; m_hold = 0;
    if (synced != m_level) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_level = !m_level;
      m_run   = 0;
      if (m_level) begin
        m_press      = 1;
        m_count      = (m_count + 1) % 256;
        m_press_edge = m_edge;
      end else begin
        m_rel = 1;
      end
    end
    if (m_level && m_edge == m_press_edge + H) m_hold = 1;
    m_edge++;
  endtask

  task automatic seg_clear();
    seg_steps = 0; seg_press_at = -1; seg_rel_at = -1; seg_hold_at = -1;
    seg_press_n = 0; seg_rel_n = 0; seg_hold_n = 0;
  endtask

  task automatic edge_check(input bit b);
    @(posedge i_clk);
    model_edge(b);
    #1;
    chk("btn", 9'(o_btn), 9'(m_level));
    chk("press", 9'(o_press), 9'(m_press));
    chk("release", 9'(o_release), 9'(m_rel));
    chk("hold", 9'(o_hold), 9'(m_hold));
    chk("count", 9'(o_count), 9'(m_count));
    chk("press_and_release", 9'(o_press & o_release), 9'd0);
    chk("press_and_hold", 9'(o_press & o_hold), 9'd0);
    chk("hold_without_btn", 9'(o_hold & !o_btn), 9'd0);
    if (o_press === 1'b1) begin
      seg_press_n++;
      if (seg_press_at < 0) seg_press_at = seg_steps;
    end
    if (o_release === 1'b1) begin
      seg_rel_n++;
      if (seg_rel_at < 0) seg_rel_at = seg_steps;
    end
    if (o_hold === 1'b1) begin
      seg_hold_n++;
      if (seg_hold_at < 0) seg_hold_at = seg_steps;
    end
    seg_steps++;
  endtask

  task automatic step(input bit b);
    @(negedge i_clk);
    i_btn = b;
    edge_check(b);
  endtask

  task automatic release_reset_step(input bit b);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_btn = b;
    edge_check(b);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_btn"}, 9'(o_btn), 9'd0);
    chk({tag, "_press"}, 9'(o_press), 9'd0);
    chk({tag, "_release"}, 9'(o_release), 9'd0);
    chk({tag, "_hold"}, 9'(o_hold), 9'd0);
    chk({tag, "_count"}, 9'(o_count), 9'd0);
  endtask

  initial begin
    bit lvl;
    int len;
    bit bounce [5];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    model_reset();
    seg_clear();
    #12;
    check_all_zero("reset");

    // Clean press from reset, held 10 cycles, then clean release.
    release_reset_step(1'b1);
    for (int i = 1; i < 10; i++) step(1'b1);
    chk("clean_press_at", 9'(seg_press_at), 9'd6);
    chk("clean_press_n", 9'(seg_press_n), 9'd1);
    chk("clean_btn", 9'(o_btn), 9'd1);
    chk("clean_count", 9'(o_count), 9'd1);
    seg_clear();
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("clean_release_at", 9'(seg_rel_at), 9'd6);
    chk("clean_release_n", 9'(seg_rel_n), 9'd1);
    chk("clean_release_btn", 9'(o_btn), 9'd0);
    chk("clean_no_hold", 9'(seg_hold_n), 9'd0);

    // Bounce shorter than the debounce window.
    seg_clear();
    for (int i = 0; i < 5; i++) step(bounce[i]);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("bounce_press_n", 9'(seg_press_n), 9'd0);
    chk("bounce_release_n", 9'(seg_rel_n), 9'd0);
    chk("bounce_btn", 9'(o_btn), 9'd0);
    chk("bounce_count", 9'(o_count), 9'd1);

    // Long hold: exactly one hold pulse, H cycles after the press pulse.
    seg_clear();
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("long_press_n", 9'(seg_press_n), 9'd1);
    chk("long_hold_n", 9'(seg_hold_n), 9'd1);
    chk("long_hold_delay", 9'(seg_hold_at - seg_press_at), 9'(H));
    chk("long_count", 9'(o_count), 9'd2);
    for (int i = 0; i < 10; i++) step(1'b0);

    // Count wrap: 256 presses from reset return to 0, the next gives 1.
    @(negedge i_clk);
    i_reset_n = 1'b0;
    i_btn = 1'b0;
    model_reset();
    #1;
    check_all_zero("wrap_reset");
    release_reset_step(1'b0);
    seg_clear();
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 6; i++) step(1'b1);
      for (int i = 0; i < 7; i++) step(1'b0);
    end
    chk("wrap_press_n", 9'(seg_press_n), 9'd256);
    chk("wrap_count", 9'(o_count), 9'd0);
    for (int i = 0; i < 6; i++) step(1'b1);
    for (int i = 0; i < 7; i++) step(1'b0);
    chk("wrap_count_257", 9'(o_count), 9'd1);

    // Randomised segments of bounce and stable levels.
    for (int s = 0; s < 60; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) step(lvl);
    end
    for (int i = 0; i < 10; i++) step(1'b0);

    // Asynchronous reset while PRESSED, button still held afterwards.
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("midreset_btn_before", 9'(o_btn), 9'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge i_clk);
    #1;
    check_all_zero("midreset_held");
    seg_clear();
    release_reset_step(1'b1);
    for (int i = 1; i < 10; i++) step(1'b1);
    chk("midreset_press_at", 9'(seg_press_at), 9'd6);
    chk("midreset_count", 9'(o_count), 9'd1);
    for (int i = 0; i < 10; i++) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
